block_fill_responder: RTL and testbench

Main-memory side of the cache block-fill interface: accepts one block request at a time from the cache controller, returns a 4-word read burst after a fixed access latency, or absorbs a 4-word write-back burst. Sits between the cache and the word-addressed backing store (15-bit word address, 32-bit words, 4-word blocks), replacing the combinational memory model with a cycle-accurate, handshaked responder.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_array.sv | 48 ++++
 rtl/block_fill_responder.sv | 158 +++++++++++++++
 tb/tb_block_fill_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and geometry for the cache block-fill responder and its word RAM.
package mem_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int WORDS  = 4;
    localparam int OFF_W  = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READ,
        WRITE
    } state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM, synchronous read and write, backing store of the block-fill responder.
module mem_array #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    // Words are stored XOR-ed with their own address, so the all-zero power-up array reads back word[a] = a.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] addr_ext;
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    always_comb begin
        addr_ext = DATA_W'(addr);
        rdata_d  = rdata_q;
        if (en && !we) begin
            rdata_d = mem[addr] ^ addr_ext;
        end
    end

    // NOTE: the storage array has no reset; contents must survive a reset pulse, and a reset loop over 32K words would not map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata ^ addr_ext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/block_fill_responder.sv
// Memory-side responder for cache block fills: fixed-latency 4-word read bursts and write-back bursts.
module block_fill_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = mem_pkg::ADDR_W,
    parameter int DATA_W  = mem_pkg::DATA_W,
    parameter int WORDS   = mem_pkg::WORDS,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int BLK_W = ADDR_W - OFF_W;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

    state_e             state_d, state_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic [OFF_W-1:0]   beat_d, beat_q;
    logic [BLK_W-1:0]   blk_d, blk_q;
    logic               req_ready_d, req_ready_q;
    logic               wr_ready_d, wr_ready_q;
    logic               rd_valid_d, rd_valid_q;
    logic               rd_last_d, rd_last_q;

    logic               issue_rd;
    logic               ram_en;
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_addr;

    logic               unused_offset_bits;
    assign unused_offset_bits = ^req_addr[OFF_W-1:0];

    // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        beat_d      = beat_q;
        blk_d       = blk_q;
        req_ready_d = req_ready_q;
        wr_ready_d  = wr_ready_q;
        rd_valid_d  = 1'b0;
        rd_last_d   = 1'b0;
        issue_rd    = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = {blk_q, beat_q};

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    blk_d       = req_addr[ADDR_W-1:OFF_W];
                    beat_d      = '0;
                    req_ready_d = 1'b0;
                    if (req_we) begin
                        state_d    = WRITE;
                        wr_ready_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                // The first RAM read goes out on the last countdown edge so data lands with rd_valid.
                if (cnt_q == '0) begin
                    state_d  = READ;
                    issue_rd = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            READ: begin
                if (rd_last_q) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                end else begin
                    issue_rd = 1'b1;
                end
            end
            WRITE: begin
                if (wr_valid && wr_ready_q) begin
                    ram_en = 1'b1;
                    ram_we = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d     = IDLE;
                        wr_ready_d  = 1'b0;
                        req_ready_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue_rd) begin
            ram_en     = 1'b1;
            rd_valid_d = 1'b1;
            rd_last_d  = (beat_q == LAST_BEAT);
            beat_d     = beat_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            beat_q      <= '0;
            blk_q       <= '0;
            req_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
            blk_q       <= blk_d;
            req_ready_q <= req_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wr_data),
        .rdata (rd_data)
    );

    assign req_ready = req_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;

endmodule

// File: tb/tb_block_fill_responder.sv
// Scoreboard bench for block_fill_responder: directed scenarios plus random bursts against a word-array model.
module tb_block_fill_responder;

    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 32;
    localparam int WORDS   = 4;
    localparam int LATENCY = 3;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              req_we = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    block_fill_responder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .WORDS  (WORDS),
        .LATENCY(LATENCY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_we   (req_we),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_last  (rd_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        int                cyc;
    } beat_t;

    logic [DATA_W-1:0] model [DEPTH];
    beat_t             exp_q[$];
    beat_t             mon_e;
    int                n_checks = 0;
    int                n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Read-beat monitor: each expected beat carries the cycle it must appear in.
    always @(negedge clk) begin
        if (rst) begin
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("rd_valid_unexpected", rd_valid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rd_data", rd_data, mon_e.data);
                    check("rd_last", rd_last, mon_e.last);
                    check("rd_cycle", cyc, mon_e.cyc);
                end
            end else if (exp_q.size() > 0 && cyc >= exp_q[0].cyc) begin
                mon_e = exp_q.pop_front();
                check("rd_valid_missing", rd_valid, 1'b1);
            end
        end
    end

    // Presents a request from a negedge and returns the edge number it was accepted on (-1 on timeout).
    task automatic issue_req(input logic [ADDR_W-1:0] a, input logic we, output int k);
        int    budget = 0;
        int    base;
        beat_t e;
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = we;
        while (!req_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            check("req_accept_timeout", req_ready, 1'b1);
            req_valid = 1'b0;
            k = -1;
            return;
        end
        @(negedge clk);
        k = cyc;
        req_valid = 1'b0;
        if (!we) begin
            base = (int'(a) / WORDS) * WORDS;
            for (int i = 0; i < WORDS; i++) begin
                e.data = model[base + i];
                e.last = (i == WORDS - 1);
                e.cyc  = k + LATENCY + i;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_idle(input int exp_cyc);
        int budget = 0;
        while (!req_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("req_ready_return_cycle", cyc, exp_cyc);
    endtask

    task automatic read_block(input logic [ADDR_W-1:0] a);
        int k;
        issue_req(a, 1'b0, k);
        if (k >= 0) wait_idle(k + LATENCY + WORDS);
    endtask

    task automatic write_block(input logic [ADDR_W-1:0] a, input logic [WORDS-1:0][DATA_W-1:0] d,
                               input int nbeats, input int gap_before);
        int k;
        int base;
        int budget;
        issue_req(a, 1'b1, k);
        if (k < 0) return;
        check("wr_ready_after_accept", wr_ready, 1'b1);
        base = (int'(a) / WORDS) * WORDS;
        for (int i = 0; i < nbeats; i++) begin
            if (i == gap_before) begin
                wr_valid = 1'b0;
                @(negedge clk);
                check("wr_ready_in_gap", wr_ready, 1'b1);
            end
            wr_valid = 1'b1;
            wr_data  = d[i];
            budget   = 0;
            while (!wr_ready && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            if (!wr_ready) begin
                check("wr_ready_timeout", wr_ready, 1'b1);
                wr_valid = 1'b0;
                return;
            end
            @(negedge clk);
            model[base + i] = d[i];
        end
        wr_valid = 1'b0;
        if (nbeats == WORDS) begin
            check("req_ready_after_write", req_ready, 1'b1);
            check("wr_ready_after_write", wr_ready, 1'b0);
        end
    endtask

    // Called from a negedge; asserts reset off-edge, checks reset values, releases and checks IDLE.
    task automatic pulse_reset();
        #2;
        rst       = 1'b0;
        req_valid = 1'b0;
        wr_valid  = 1'b0;
        exp_q.delete();
        #1;
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_last", rd_last, 1'b0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_wr_ready", wr_ready, 1'b0);
        check("rst_req_ready", req_ready, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_hold_req_ready", req_ready, 1'b0);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1'b1);
        check("post_rst_rd_valid", rd_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k1, k2;
        int budget;
        logic [WORDS-1:0][DATA_W-1:0] d;
        logic [ADDR_W-1:0] a;

        for (int i = 0; i < DEPTH; i++) model[i] = DATA_W'(i);

        repeat (2) @(negedge clk);
        pulse_reset();

        // Plain read and offset-ignored read of the same block.
        read_block(15'd1024);
        read_block(15'd1026);

        // Write-back with a one-cycle gap, then read back via a different offset.
        for (int i = 0; i < WORDS; i++) d[i] = 32'hAAAA_0000 + i;
        write_block(15'd2048, d, WORDS, 2);
        read_block(15'd2049);

        // req_valid held across two reads; the second one is the top block.
        issue_req(15'd1024, 1'b0, k1);
        issue_req(15'd32767, 1'b0, k2);
        check("back_to_back_accept", k2, k1 + LATENCY + WORDS + 1);
        wait_idle(k2 + LATENCY + WORDS);

        // Reset while beat 2 of a read is on the bus.
        issue_req(15'd1024, 1'b0, k1);
        budget = 0;
        while (cyc < k1 + LATENCY + 2 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("beat2_visible", rd_valid, 1'b1);
        pulse_reset();
        read_block(15'd1024);

        // Reset after two write beats: only those two words change.
        for (int i = 0; i < WORDS; i++) d[i] = 32'h5555_0000 + i;
        write_block(15'd4096, d, 2, -1);
        pulse_reset();
        read_block(15'd4096);

        // Random traffic: writes are read back through a random offset of the same block.
        for (int n = 0; n < 20; n++) begin
            a = ADDR_W'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < WORDS; i++) d[i] = $urandom;
                write_block(a, d, WORDS, int'($urandom_range(0, WORDS)));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                read_block({a[ADDR_W-1:2], 2'($urandom_range(0, 3))});
            end else begin
                read_block(a);
            end
        end

        budget = 0;
        while (exp_q.size() > 0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
